// File: rtl/map_state_ctrl.sv
// rtl/map_state_ctrl.sv - Life map generation register with run/pause/step control and a generation counter.
// Optional MAP_AUTO_HALT_EN: a RUN commit that leaves the map stable or extinct also moves the FSM to HALT.
module map_state_ctrl #(
   parameter int map_width  = 8,
   parameter int map_height = 8,
   parameter int GEN_W      = 16
) (
   input  logic                          clock,
   input  logic                          reset,
   input  logic                          enable,
   input  logic                          load,
   input  logic                          start,
   input  logic                          stop,
   input  logic                          step,
   input  logic [map_width*map_height-1:0] state_in,
   input  logic [map_width*map_height-1:0] state_init,
   output logic [map_width*map_height-1:0] state_out,
   output logic [GEN_W-1:0]              generation,
   output logic                          running,
   output logic                          halted,
   output logic                          extinct,
   output logic                          stable
);

   localparam int N = map_width * map_height;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_PAUSE = 2'd1,
      ST_RUN   = 2'd2,
      ST_HALT  = 2'd3
   } state_t;

   state_t           state_q, state_d;
   logic [N-1:0]     map_q, map_d;
   logic [GEN_W-1:0] gen_q, gen_d;
   logic             extinct_q, extinct_d;
   logic             stable_q, stable_d;

   logic             commit;
   logic             next_stable;
   logic             next_extinct;

   // A commit needs no higher-priority command this cycle (load, stop in RUN, start in PAUSE).
   assign commit = !load &&
                   (((state_q == ST_RUN)   && !stop  && enable) ||
                    ((state_q == ST_PAUSE) && !start && step && enable));

   assign next_stable  = (state_in == map_q);
   assign next_extinct = (state_in == '0);

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q   <= ST_IDLE;
         map_q     <= '0;
         gen_q     <= '0;
         extinct_q <= 1'b0;
         stable_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         map_q     <= map_d;
         gen_q     <= gen_d;
         extinct_q <= extinct_d;
         stable_q  <= stable_d;
      end
   end

   always_comb begin
      state_d = state_q;
      if (load) begin
         state_d = ST_PAUSE;
      end else begin
         case (state_q)
            ST_PAUSE: if (start) state_d = ST_RUN;
            ST_RUN: begin
               if (stop) begin
                  state_d = ST_PAUSE;
`ifdef MAP_AUTO_HALT_EN
               end else if (commit && (next_stable || next_extinct)) begin
                  state_d = ST_HALT;
`endif
               end
            end
            default: state_d = state_q;
         endcase
      end
   end

   always_comb begin
      map_d     = map_q;
      gen_d     = gen_q;
      extinct_d = extinct_q;
      stable_d  = stable_q;
      if (load) begin
         map_d     = state_init;
         gen_d     = '0;
         stable_d  = 1'b0;
         extinct_d = (state_init == '0);
      end else if (commit) begin
         map_d     = state_in;
         gen_d     = (gen_q == {GEN_W{1'b1}}) ? gen_q : gen_q + 1'b1;
         stable_d  = next_stable;
         extinct_d = next_extinct;
      end
   end

   always_comb begin
      state_out  = map_q;
      generation = gen_q;
      extinct    = extinct_q;
      stable     = stable_q;
      running    = (state_q == ST_RUN);
`ifdef MAP_AUTO_HALT_EN
      halted     = (state_q == ST_HALT);
`else
      halted     = 1'b0;
`endif
   end

endmodule
